// File: rtl/ws2812b_pkg.sv
// Shared encodings and 10 MHz default timing for the WS2812B chain driver.
package ws2812b_pkg;

  typedef enum logic [1:0] {
    MODE_MASK = 2'b00,
    MODE_DOT  = 2'b01,
    MODE_BAR  = 2'b10,
    MODE_INV  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SEND  = 2'b10,
    ST_LATCH = 2'b11
  } state_e;

  localparam int DEF_NUM_LEDS   = 12;
  localparam int DEF_T0H_CYC    = 4;
  localparam int DEF_T1H_CYC    = 8;
  localparam int DEF_TBIT_CYC   = 13;
  localparam int DEF_TRES_CYC   = 3000;
  localparam int BITS_PER_PIXEL = 24;

endpackage

// File: rtl/ws2812b_bit_encoder.sv
// Emits one WS2812B bit: high for T0H/T1H cycles, low until TBIT_CYC, then a done pulse.
module ws2812b_bit_encoder
  import ws2812b_pkg::*;
#(
  parameter int T0H_CYC  = DEF_T0H_CYC,
  parameter int T1H_CYC  = DEF_T1H_CYC,
  parameter int TBIT_CYC = DEF_TBIT_CYC
) (
  input  logic clk,
  input  logic res,
  input  logic start,
  input  logic bit_in,
  output logic dout,
  output logic done
);

  localparam int CW = (TBIT_CYC > 2) ? $clog2(TBIT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TBIT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;
  logic          bit_q, bit_d;
  logic          dout_q, dout_d;

  assign done = active_q && (cnt_q == CNT_LAST);
  assign dout = dout_q;

  // A start coinciding with done chains the next bit with no idle cycle.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    bit_d    = bit_q;
    dout_d   = 1'b0;
    if (start) begin
      cnt_d    = '0;
      active_d = 1'b1;
      bit_d    = bit_in;
      dout_d   = (bit_in ? T1H_CYC : T0H_CYC) > 0;
    end else if (active_q) begin
      if (done) begin
        active_d = 1'b0;
      end else begin
        cnt_d  = cnt_q + CW'(1);
        dout_d = (int'(cnt_q) + 1) < (bit_q ? T1H_CYC : T0H_CYC);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      active_q <= 1'b0;
      dout_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      dout_q   <= dout_d;
    end
    cnt_q <= cnt_d;
    bit_q <= bit_d;
  end

endmodule

// File: rtl/ws2812b_chain_driver.sv
// WS2812B frame driver: snapshots display settings on refresh, streams NUM_LEDS GRB
// words MSB-first, then holds the line low for the latch period.
module ws2812b_chain_driver
  import ws2812b_pkg::*;
#(
  parameter int  NUM_LEDS = DEF_NUM_LEDS,
  parameter int  T0H_CYC  = DEF_T0H_CYC,
  parameter int  T1H_CYC  = DEF_T1H_CYC,
  parameter int  TBIT_CYC = DEF_TBIT_CYC,
  parameter int  TRES_CYC = DEF_TRES_CYC,
  localparam int PW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                clk,
  input  logic                res,
  input  logic                refresh,
  input  logic [1:0]          mode,
  input  logic [NUM_LEDS-1:0] led_mask,
  input  logic [PW-1:0]       position,
  input  logic [2:0]          colour,
  input  logic [7:0]          intensity,
  output logic                busy,
  output logic                frame_done,
  output logic                led_dout
);

  localparam int LW = $clog2(TRES_CYC + 1);
  localparam logic [PW-1:0] LAST_PIX = PW'(NUM_LEDS - 1);
  localparam logic [4:0]    LAST_BIT = 5'(BITS_PER_PIXEL - 1);

  state_e                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  pending_q, pending_d;
  logic [PW-1:0]         pix_q, pix_d;
  logic [4:0]            bit_idx_q, bit_idx_d;
  logic [23:0]           shift_q, shift_d;
  logic [LW-1:0]         latch_q, latch_d;

  mode_e                 snap_mode_q, snap_mode_d;
  logic [NUM_LEDS-1:0]   snap_mask_q, snap_mask_d;
  logic [PW-1:0]         snap_pos_q, snap_pos_d;
  logic [2:0]            snap_col_q, snap_col_d;
  logic [7:0]            snap_int_q, snap_int_d;

  logic                  snap_en;
  logic                  enc_start;
  logic                  enc_bit;
  logic                  enc_done;
  logic                  enc_dout;
  logic [23:0]           word;

  // Out-of-range dot/bar positions pin to the last pixel instead of wrapping.
  function automatic logic [PW-1:0] clamp_pos(input logic [PW-1:0] p);
    if (int'(p) > NUM_LEDS - 1) return LAST_PIX;
    return p;
  endfunction

  function automatic logic pixel_on(input logic [PW-1:0] idx, input mode_e m,
                                    input logic [NUM_LEDS-1:0] mask,
                                    input logic [PW-1:0] pos);
    case (m)
      MODE_MASK: return mask[idx];
      MODE_DOT:  return idx == pos;
      MODE_BAR:  return idx <= pos;
      default:   return ~mask[idx];
    endcase
  endfunction

  function automatic logic [23:0] grb_word(input logic on, input logic [2:0] col,
                                          input logic [7:0] inten);
    logic [7:0] g, r, b;
    g = (on && col[1]) ? inten : 8'h00;
    r = (on && col[2]) ? inten : 8'h00;
    b = (on && col[0]) ? inten : 8'h00;
    return {g, r, b};
  endfunction

  assign word = grb_word(pixel_on(pix_q, snap_mode_q, snap_mask_q, snap_pos_q),
                         snap_col_q, snap_int_q);

  always_comb begin
    snap_mode_d = snap_en ? mode_e'(mode)       : snap_mode_q;
    snap_mask_d = snap_en ? led_mask            : snap_mask_q;
    snap_pos_d  = snap_en ? clamp_pos(position) : snap_pos_q;
    snap_col_d  = snap_en ? colour              : snap_col_q;
    snap_int_d  = snap_en ? intensity           : snap_int_q;
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    pix_d     = pix_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    latch_d   = latch_q;
    snap_en   = 1'b0;
    enc_start = 1'b0;
    enc_bit   = 1'b0;

    if (refresh && (state_q != ST_IDLE)) pending_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (refresh) begin
          snap_en = 1'b1;
          pix_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        enc_start = 1'b1;
        enc_bit   = word[23];
        shift_d   = {word[22:0], 1'b0};
        bit_idx_d = '0;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (enc_done) begin
          if (bit_idx_q == LAST_BIT) begin
            if (pix_q == LAST_PIX) begin
              latch_d = LW'(TRES_CYC - 1);
              state_d = ST_LATCH;
            end else begin
              pix_d   = pix_q + PW'(1);
              state_d = ST_LOAD;
            end
          end else begin
            enc_start = 1'b1;
            enc_bit   = shift_q[23];
            shift_d   = {shift_q[22:0], 1'b0};
            bit_idx_d = bit_idx_q + 5'd1;
          end
        end
      end
      default: begin
        if (latch_q == '0) begin
          // A request seen during the frame, or on this very cycle, chains the next frame.
          if (pending_q || refresh) begin
            pending_d = 1'b0;
            snap_en   = 1'b1;
            pix_d     = '0;
            state_d   = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          latch_d = latch_q - LW'(1);
        end
      end
    endcase

    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_LATCH) && (latch_d == '0);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      pending_q    <= 1'b0;
      pix_q        <= '0;
      bit_idx_q    <= '0;
      latch_q      <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      pending_q    <= pending_d;
      pix_q        <= pix_d;
      bit_idx_q    <= bit_idx_d;
      latch_q      <= latch_d;
    end
    shift_q     <= shift_d;
    snap_mode_q <= snap_mode_d;
    snap_mask_q <= snap_mask_d;
    snap_pos_q  <= snap_pos_d;
    snap_col_q  <= snap_col_d;
    snap_int_q  <= snap_int_d;
  end

  ws2812b_bit_encoder #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .TBIT_CYC(TBIT_CYC)
  ) u_bit_encoder (
    .clk   (clk),
    .res   (res),
    .start (enc_start),
    .bit_in(enc_bit),
    .dout  (enc_dout),
    .done  (enc_done)
  );

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign led_dout   = enc_dout;

endmodule

// File: tb/tb_ws2812b_chain_driver.sv
// Scoreboard bench: stimulus queues expected GRB words, a line decoder pops and compares.
module tb_ws2812b_chain_driver;

  localparam int NUM   = 12;
  localparam int PW    = 4;
  localparam int T0H   = 4;
  localparam int T1H   = 8;
  localparam int TBIT  = 13;
  localparam int TRES  = 3000;
  localparam int FRAME = NUM * (1 + 24 * TBIT) + TRES;

  logic           clk = 1'b0;
  logic           res = 1'b1;
  logic           refresh = 1'b0;
  logic [1:0]     mode = 2'b00;
  logic [NUM-1:0] led_mask = '0;
  logic [PW-1:0]  position = '0;
  logic [2:0]     colour = '0;
  logic [7:0]     intensity = '0;
  logic           busy, frame_done, led_dout;

  int             checks = 0;
  int             failures = 0;
  logic [23:0]    exp_q[$];
  int             cyc = 0;
  int             fd_count = 0;
  int             busy_rise = 0;
  int             last_busy_len = 0;

  always #5 clk = ~clk;

  ws2812b_chain_driver #(
    .NUM_LEDS(NUM), .T0H_CYC(T0H), .T1H_CYC(T1H), .TBIT_CYC(TBIT), .TRES_CYC(TRES)
  ) dut (
    .clk(clk), .res(res), .refresh(refresh), .mode(mode), .led_mask(led_mask),
    .position(position), .colour(colour), .intensity(intensity),
    .busy(busy), .frame_done(frame_done), .led_dout(led_dout)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: which pixels are lit and which channels carry the intensity.
  function automatic logic [23:0] model_word(input int i, input int m, input logic [NUM-1:0] mask,
                                             input int position_in, input logic [2:0] col,
                                             input logic [7:0] inten);
    int  p;
    bit  on;
    logic [7:0] g, r, b;
    p = (position_in > NUM - 1) ? NUM - 1 : position_in;
    case (m)
      0:       on = mask[i];
      1:       on = (i == p);
      2:       on = (i <= p);
      default: on = !mask[i];
    endcase
    g = (on && col[1]) ? inten : 8'h00;
    r = (on && col[2]) ? inten : 8'h00;
    b = (on && col[0]) ? inten : 8'h00;
    return {g, r, b};
  endfunction

  task automatic set_in(input logic [1:0] m, input logic [NUM-1:0] mk, input logic [PW-1:0] p,
                        input logic [2:0] c, input logic [7:0] it);
    mode = m; led_mask = mk; position = p; colour = c; intensity = it;
  endtask

  task automatic set_random();
    set_in(2'($urandom), 12'($urandom), 4'($urandom), 3'($urandom), 8'($urandom));
  endtask

  task automatic push_frame(input int npix);
    for (int i = 0; i < npix; i++)
      exp_q.push_back(model_word(i, int'(mode), led_mask, int'(position), colour, intensity));
  endtask

  task automatic pulse_refresh();
    @(negedge clk); refresh = 1'b1;
    @(negedge clk); refresh = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(posedge clk); #1; n++;
    end
    @(negedge clk);
    chk("busy_timeout", busy, 0);
  endtask

  task automatic run_frame();
    int fd0;
    push_frame(NUM);
    fd0 = fd_count;
    pulse_refresh();
    chk("busy_rise", busy, 1);
    wait_idle(2 * FRAME);
    chk("busy_len", last_busy_len, FRAME);
    chk("frame_done_cnt", fd_count - fd0, 1);
  endtask

  // Line decoder: measures high time and rise-to-rise spacing, rebuilds pixels.
  initial begin
    logic        prev_d, prev_b, bitv;
    logic [23:0] acc, e;
    int          last_rise, nbits, hl;
    bit          rise_valid;
    prev_d = 1'b0; prev_b = 1'b0; acc = '0; last_rise = 0; nbits = 0; rise_valid = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (busy && !prev_b) busy_rise = cyc;
      if (!busy && prev_b) last_busy_len = cyc - busy_rise;
      prev_b = busy;
      if (res) begin
        nbits = 0; rise_valid = 0; prev_d = 1'b0;
      end else begin
        if (led_dout && !prev_d) begin
          if (rise_valid && (cyc - last_rise) < 2000)
            chk("bit_period", cyc - last_rise, (nbits == 0) ? TBIT + 1 : TBIT);
          last_rise = cyc; rise_valid = 1;
        end else if (!led_dout && prev_d) begin
          hl   = cyc - last_rise;
          bitv = (hl > (T0H + T1H) / 2);
          chk("bit_high", hl, bitv ? T1H : T0H);
          acc = {acc[22:0], bitv};
          nbits++;
          if (nbits == 24) begin
            nbits = 0;
            chk("pixel_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              chk("pixel", acc, e);
            end
          end
        end
        if (frame_done) begin
          fd_count++;
          chk("latch_len", cyc - last_rise, TBIT + TRES - 1);
        end
        prev_d = led_dout;
      end
    end
  end

  initial begin
    #(1_500_000);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_dout", led_dout, 0);
    @(negedge clk); res = 1'b0;

    // Single red pixel at full intensity.
    set_in(2'b00, 12'h001, 4'd0, 3'b100, 8'hFF);
    run_frame();

    // Dot clamped to the last pixel, then a four-pixel white bar.
    set_in(2'b01, 12'($urandom), 4'd15, 3'b010, 8'hA5);
    run_frame();
    set_in(2'b10, 12'($urandom), 4'd3, 3'b111, 8'h10);
    run_frame();

    // Three refreshes mid-frame coalesce into one follow-on frame with the new mask.
    set_in(2'b00, 12'($urandom), 4'd0, 3'($urandom_range(1, 7)), 8'($urandom_range(1, 255)));
    push_frame(NUM);
    fd0 = fd_count;
    pulse_refresh();
    repeat (500) @(negedge clk);
    pulse_refresh();
    led_mask = led_mask ^ (12'($urandom) | 12'h001);
    repeat (1000) @(negedge clk);
    pulse_refresh();
    repeat (1000) @(negedge clk);
    pulse_refresh();
    push_frame(NUM);
    wait_idle(3 * FRAME);
    chk("pending_busy_len", last_busy_len, 2 * FRAME);
    chk("pending_frame_cnt", fd_count - fd0, 2);
    repeat (50) @(negedge clk);
    chk("no_third_frame", busy, 0);

    // Reset in the middle of pixel 5, bit 10.
    set_in(2'b00, 12'($urandom), 4'd0, 3'b111, 8'($urandom_range(1, 255)));
    push_frame(5);
    fd0 = fd_count;
    pulse_refresh();
    repeat (1700) @(negedge clk);
    res = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_dout", led_dout, 0);
    chk("rst_mid_busy", busy, 0);
    @(negedge clk); res = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_mid_idle", busy, 0);
    chk("rst_mid_no_done", fd_count - fd0, 0);
    chk("rst_mid_pixels", exp_q.size(), 0);
    set_random();
    run_frame();

    // Inverted full mask gives a dark but fully timed frame; refresh on frame_done chains.
    set_in(2'b11, 12'hFFF, 4'd0, 3'b111, 8'hFF);
    push_frame(NUM);
    fd0 = fd_count;
    pulse_refresh();
    n = 0;
    while (!frame_done && n < 2 * FRAME) begin
      @(posedge clk); #1; n++;
    end
    chk("done_seen", frame_done, 1);
    set_random();
    refresh = 1'b1;
    push_frame(NUM);
    @(posedge clk); #1;
    refresh = 1'b0;
    chk("busy_held", busy, 1);
    wait_idle(2 * FRAME);
    chk("chain_busy_len", last_busy_len, 2 * FRAME);
    chk("chain_frame_cnt", fd_count - fd0, 2);

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
